// File: rtl/mem_addr_seq.sv
// Memory-address sequencer: latches one of several address sources on an
// accepted start, runs a req/ready handshake with memory and reports completion
// with a one-cycle done pulse, plus err for misalignment or an invalid select.
// Optional macro MEM_TIMEOUT_EN adds a REQ-state watchdog that aborts with err
// after TIMEOUT cycles without mem_ready.
module mem_addr_seq #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned VEC_N    = 3,
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [SEL_W-1:0]  seletor_i,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [ADDR_W-1:0] aluout_data_i,
  input  logic [ADDR_W-1:0] pc_data_i,
  input  logic              word_acc_i,
  input  logic              start_i,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] addr_out_o,
  output logic              mem_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

  // Select codes: 0 ALU result, 1 ALUOut, 2..VEC_N+1 vectors, VEC_N+2 PC.
  localparam logic [SEL_W-1:0] SelAlu    = SEL_W'(0);
  localparam logic [SEL_W-1:0] SelAluOut = SEL_W'(1);
  localparam logic [SEL_W-1:0] SelVecLo  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SelVecHi  = SEL_W'(VEC_N + 1);
  localparam logic [SEL_W-1:0] SelPc     = SEL_W'(VEC_N + 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_valid;
  logic              misalign;
  logic              req_timeout;

  // Address source mux; unmapped codes yield address 0 and flag invalid.
  always_comb begin
    sel_addr  = '0;
    sel_valid = 1'b1;
    if (seletor_i == SelAlu) begin
      sel_addr = alu_result_i;
    end else if (seletor_i == SelAluOut) begin
      sel_addr = aluout_data_i;
    end else if (seletor_i >= SelVecLo && seletor_i <= SelVecHi) begin
      sel_addr = ADDR_W'(VEC_BASE) + ADDR_W'(seletor_i) - ADDR_W'(2);
    end else if (seletor_i == SelPc) begin
      sel_addr = pc_data_i;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Only word accesses care about the two low address bits.
  assign misalign = word_acc_i && (sel_addr[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count REQ cycles without mem_ready; held at zero everywhere else so
  // every entry to REQ starts from a clean count.
  always_comb begin
    cnt_d = '0;
    if (state_q == StReq && !mem_ready_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th REQ cycle; mem_ready in that cycle still wins.
  assign req_timeout = (cnt_q == CntW'(TIMEOUT - 1));
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign req_timeout    = 1'b0;
`endif

  // Next-state logic for the IDLE/REQ/FIN handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d = sel_addr;
          if (!sel_valid || misalign) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            err_d   = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ready_i) begin
          err_d   = 1'b0;
          state_d = StFin;
        end else if (req_timeout) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State, latched address and error flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign addr_out_o = addr_q;
  assign mem_req_o  = (state_q == StReq);
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StFin);
  assign err_o      = (state_q == StFin) && err_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Self-checking bench for mem_addr_seq: directed vector table, randomized
// accesses against a behavioural model, and hand sequences for reset and
// start-during-FIN. Define MEM_TIMEOUT_EN on both files to cover the watchdog.
module tb_mem_addr_seq;

  localparam int VEC_N    = 3;
  localparam int VEC_BASE = 253;
  localparam int TIMEOUT  = 15;
  localparam int MAX_CYC  = 40;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  seletor;
  logic [31:0] alu_result, aluout_data, pc_data;
  logic        word_acc, start, mem_ready;
  logic [31:0] addr_out;
  logic        mem_req, busy, done, err;

  int total = 0;
  int bad   = 0;

  mem_addr_seq #(
    .ADDR_W  (32),
    .SEL_W   (3),
    .VEC_N   (VEC_N),
    .VEC_BASE(VEC_BASE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .seletor_i    (seletor),
    .alu_result_i (alu_result),
    .aluout_data_i(aluout_data),
    .pc_data_i    (pc_data),
    .word_acc_i   (word_acc),
    .start_i      (start),
    .mem_ready_i  (mem_ready),
    .addr_out_o   (addr_out),
    .mem_req_o    (mem_req),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] alu;
    logic [31:0] aluout;
    logic [31:0] pc;
    logic        wacc;
    int          delay;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Spec-level address map and error rule.
  function automatic void model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] p, input logic w,
                                output logic [31:0] addr, output logic e);
    int s;
    bit valid;
    s     = int'(sel);
    valid = 1'b1;
    if (s == 0) addr = a;
    else if (s == 1) addr = b;
    else if (s >= 2 && s < 2 + VEC_N) addr = 32'(VEC_BASE + s - 2);
    else if (s == VEC_N + 2) addr = p;
    else begin
      addr  = 32'd0;
      valid = 1'b0;
    end
    e = !valid || (w && (addr % 4 != 0));
  endfunction

  // One complete access starting at posedge+1 in IDLE. mem_ready rises in the
  // (delay+1)-th REQ cycle. Expected address/err come from the caller.
  task automatic run_access(input string tag, input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] p, input logic w,
                            input int delay, input logic [31:0] ea, input logic ee);
    int  cyc, reqc, exp_cyc, exp_req;
    bit  seen;
    logic exp_e;
    exp_e = ee;
    if (ee) begin
      exp_cyc = 1;
      exp_req = 0;
    end else begin
      exp_cyc = delay + 2;
      exp_req = delay + 1;
`ifdef MEM_TIMEOUT_EN
      if (delay >= TIMEOUT) begin
        exp_cyc = TIMEOUT + 1;
        exp_req = TIMEOUT;
        exp_e   = 1'b1;
      end
`endif
    end
    seletor     = sel;
    alu_result  = a;
    aluout_data = b;
    pc_data     = p;
    word_acc    = w;
    start       = 1'b1;
    mem_ready   = 1'($urandom_range(1));
    @(posedge clk); #1;
    start       = 1'b0;
    // Scramble sources: only the latched value may drive addr_out.
    seletor     = 3'($urandom);
    alu_result  = $urandom;
    aluout_data = $urandom;
    pc_data     = $urandom;
    word_acc    = 1'($urandom_range(1));
    cyc  = 1;
    reqc = 0;
    seen = 1'b0;
    while (cyc <= MAX_CYC) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mem_req) begin
        reqc++;
        if (addr_out !== ea) chk({tag, " addr_in_req"}, addr_out, ea);
        mem_ready = (reqc > delay);
      end else begin
        mem_ready = 1'b0;
      end
      start = 1'($urandom_range(1));  // ignored while busy
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " err"}, 32'(err), 32'(exp_e));
    chk({tag, " addr"}, addr_out, ea);
    chk({tag, " req_cycles"}, 32'(reqc), 32'(exp_req));
    chk({tag, " req_in_fin"}, 32'(mem_req), 32'd0);
    mem_ready = 1'($urandom_range(1));
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, " addr_hold"}, addr_out, ea);
    mem_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] ea, a, b, p;
    logic        ee, w;
    logic [2:0]  s;
    int          d;

    vecs[0] = '{3'd0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 32'h100, 1'b0};
    vecs[1] = '{3'd3, 32'h0, 32'h0, 32'h0, 1'b0, 0, 32'd254, 1'b0};
    vecs[2] = '{3'd1, 32'h0, 32'h102, 32'h0, 1'b1, 0, 32'h102, 1'b1};
    vecs[3] = '{3'd7, 32'h10, 32'h20, 32'h30, 1'b0, 0, 32'h0, 1'b1};
    vecs[4] = '{3'd5, 32'h1, 32'h2, 32'h4000, 1'b1, 3, 32'h4000, 1'b0};
    vecs[5] = '{3'd2, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'd253, 1'b1};
    vecs[6] = '{3'd4, 32'h0, 32'h0, 32'h0, 1'b0, 2, 32'd255, 1'b0};
    vecs[7] = '{3'd6, 32'h8, 32'h8, 32'h8, 1'b1, 0, 32'h0, 1'b1};
    vecs[8] = '{3'd1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 0, 32'hFFFF_FFFC, 1'b0};
    vecs[9] = '{3'd0, 32'h3, 32'h0, 32'h0, 1'b0, 0, 32'h3, 1'b0};

    reset_n     = 1'b0;
    seletor     = '0;
    alu_result  = '0;
    aluout_data = '0;
    pc_data     = '0;
    word_acc    = 1'b0;
    start       = 1'b0;
    mem_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset addr", addr_out, 32'd0);
    chk("reset flags", {27'd0, mem_req, busy, done, err, 1'b0}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", {30'd0, busy, done}, 32'd0);

    foreach (vecs[i]) begin
      run_access($sformatf("vec%0d", i), vecs[i].sel, vecs[i].alu, vecs[i].aluout, vecs[i].pc,
                 vecs[i].wacc, vecs[i].delay, vecs[i].exp_addr, vecs[i].exp_err);
    end

    for (int i = 0; i < 40; i++) begin
      s = 3'($urandom);
      a = $urandom;
      b = $urandom;
      p = $urandom;
      if ($urandom_range(1) == 1) begin
        a[1:0] = 2'b00;
        b[1:0] = 2'b00;
        p[1:0] = 2'b00;
      end
      w = 1'($urandom_range(1));
      d = int'($urandom_range(4));
      model(s, a, b, p, w, ea, ee);
      run_access($sformatf("rnd%0d", i), s, a, b, p, w, d, ea, ee);
    end

    // start held through FIN must not launch a new access.
    seletor = 3'd7;
    start   = 1'b1;
    @(posedge clk); #1;
    chk("fin_start done", 32'(done), 32'd1);
    seletor    = 3'd0;
    alu_result = 32'h40;
    word_acc   = 1'b1;
    @(posedge clk); #1;
    chk("fin_start ignored", {30'd0, busy, done}, 32'd0);
    chk("fin_start addr", addr_out, 32'd0);
    start = 1'b0;
    run_access("after_fin", 3'd0, 32'h40, 32'h0, 32'h0, 1'b1, 0, 32'h40, 1'b0);

    // Stall in REQ, then reset asynchronously mid-access.
    seletor    = 3'd0;
    alu_result = 32'h80;
    word_acc   = 1'b1;
    mem_ready  = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef MEM_TIMEOUT_EN
    repeat (5) @(posedge clk);
`else
    repeat (30) @(posedge clk);
`endif
    #1;
    chk("stall busy", {30'd0, busy, mem_req}, 32'd3);
    chk("stall addr", addr_out, 32'h80);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset addr", addr_out, 32'd0);
    chk("midreset flags", {28'd0, mem_req, busy, done, err}, 32'd0);
    @(posedge clk); #1;
    chk("midreset no done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_access("post_reset", 3'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1, 32'd255, 1'b0);

`ifdef MEM_TIMEOUT_EN
    run_access("timeout", 3'd0, 32'h200, 32'h0, 32'h0, 1'b1, 1000, 32'h200, 1'b0);
    run_access("limit_ready", 3'd1, 32'h0, 32'h204, 32'h0, 1'b1, TIMEOUT - 1, 32'h204, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
